// File: rtl/tpu_mmio_sequencer.sv
// Command/data sequencer in front of the TPUv1 MMIO slave.
// Streams A rows and then B rows into the TPU windows, fires one MatMul,
// waits out the compute time, then reads every C word back onto an output
// stream. One start pulse produces one complete matrix multiply.
module tpu_mmio_sequencer #(
  parameter int DIM       = 8,
  parameter int BITS_C    = 16,
  parameter int ADDRW     = 16,
  parameter int DATAW     = 64,
  parameter int MM_CYCLES = 24,
  parameter int RD_LAT    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DATAW-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATAW-1:0] out_data,
  output logic             tpu_r_w,
  output logic [ADDRW-1:0] tpu_addr,
  output logic [DATAW-1:0] tpu_wdata,
  input  logic [DATAW-1:0] tpu_rdata
);

  // Number of MMIO words making up the whole C matrix.
  localparam int NWORDS = ((DIM * BITS_C) / DATAW) * DIM;
  localparam int ROW_W  = $clog2(DIM);
  localparam int WORD_W = $clog2(NWORDS);
  localparam int WAIT_W = $clog2(MM_CYCLES + 1);

  localparam logic [ADDRW-1:0] A_BASE  = ADDRW'(16'h0100);
  localparam logic [ADDRW-1:0] B_BASE  = ADDRW'(16'h0200);
  localparam logic [ADDRW-1:0] C_BASE  = ADDRW'(16'h0300);
  localparam logic [ADDRW-1:0] MM_ADDR = ADDRW'(16'h0400);

  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(DIM - 1);
  localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(NWORDS - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MM_CYCLES - 1);
  localparam logic [WAIT_W-1:0] LAT_LAST  = WAIT_W'(RD_LAT - 1);

  typedef enum logic [3:0] {
    IDLE, LOAD_A, LOAD_B, MM_GO, MM_WAIT, RD_ADDR, RD_CAP, RD_OUT, FIN
  } state_t;

  state_t              state, state_n;
  logic [ROW_W-1:0]    row;
  logic [WORD_W-1:0]   word;
  logic [WAIT_W-1:0]   wcnt;
  logic                in_hs;
  logic                out_hs;
  logic [ADDRW-1:0]    rd_addr;

  assign in_hs  = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;
  // C words are contiguous: row r lo at +16r, hi at +16r+8, i.e. +8 per word.
  assign rd_addr = C_BASE + (ADDRW'(word) << 3);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state decode and MMIO / status outputs; MMIO bus idles at address 0.
  always_comb begin
    state_n   = state;
    tpu_r_w   = 1'b0;
    tpu_addr  = '0;
    tpu_wdata = '0;
    busy      = (state != IDLE) && (state != FIN);
    done      = (state == FIN);
    case (state)
      IDLE: begin
        if (start) state_n = LOAD_A;
      end
      LOAD_A: begin
        if (in_hs) begin
          tpu_r_w   = 1'b1;
          tpu_wdata = in_data;
          tpu_addr  = A_BASE + (ADDRW'(row) << 3);
          if (row == ROW_LAST) state_n = LOAD_B;
        end
      end
      LOAD_B: begin
        if (in_hs) begin
          tpu_r_w   = 1'b1;
          tpu_wdata = in_data;
          tpu_addr  = B_BASE + (ADDRW'(row) << 3);
          if (row == ROW_LAST) state_n = MM_GO;
        end
      end
      MM_GO: begin
        tpu_r_w  = 1'b1;
        tpu_addr = MM_ADDR;
        state_n  = MM_WAIT;
      end
      MM_WAIT: begin
        if (wcnt == WAIT_LAST) state_n = RD_ADDR;
      end
      RD_ADDR: begin
        tpu_addr = rd_addr;
        if (wcnt == LAT_LAST) state_n = RD_CAP;
      end
      RD_CAP: begin
        tpu_addr = rd_addr;
        state_n  = RD_OUT;
      end
      RD_OUT: begin
        if (out_hs) state_n = (word == WORD_LAST) ? FIN : RD_ADDR;
      end
      FIN: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Counters, registered in_ready and the output word holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row       <= '0;
      word      <= '0;
      wcnt      <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      in_ready <= (state_n == LOAD_A) || (state_n == LOAD_B);

      if (state == IDLE)  row <= '0;
      else if (in_hs)     row <= (row == ROW_LAST) ? '0 : row + 1'b1;

      if (state == IDLE)  word <= '0;
      else if (out_hs)    word <= (word == WORD_LAST) ? '0 : word + 1'b1;

      if (((state == MM_WAIT) || (state == RD_ADDR)) && (state_n == state))
        wcnt <= wcnt + 1'b1;
      else
        wcnt <= '0;

      if (state == RD_CAP) begin
        out_data  <= tpu_rdata;
        out_valid <= 1'b1;
      end else if (out_hs) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tpu_mmio_sequencer.sv
// Testbench for tpu_mmio_sequencer: directed jobs checked against a
// transaction-level model (expected MMIO writes, reads and C words).
module tb_tpu_mmio_sequencer;
  localparam int DIM       = 8;
  localparam int NW        = 2 * DIM;
  localparam int MM_CYCLES = 24;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic        done;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        tpu_r_w;
  logic [15:0] tpu_addr;
  logic [63:0] tpu_wdata;
  logic [63:0] tpu_rdata;

  tpu_mmio_sequencer #(
    .DIM(DIM), .BITS_C(16), .ADDRW(16), .DATAW(64), .MM_CYCLES(MM_CYCLES), .RD_LAT(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .tpu_r_w(tpu_r_w), .tpu_addr(tpu_addr), .tpu_wdata(tpu_wdata), .tpu_rdata(tpu_rdata)
  );

  always #5 clk = ~clk;

  // TPU read model: one-cycle latency, data = 0xC000... | address.
  logic [15:0] addr_q;
  always @(negedge clk) addr_q <= tpu_addr;
  always @(posedge clk) tpu_rdata <= {48'hC000_0000_0000, addr_q};

  typedef struct {
    logic [15:0] a;
    logic [63:0] d;
  } wr_t;

  wr_t         expw[$];
  logic [15:0] expr[$];
  logic [63:0] expo[$];
  logic [63:0] out_log[$];

  int checks = 0;
  int failures = 0;
  int n_writes, n_mm, n_done, n_stall, mm_idle, idle_cnt;
  logic [15:0] first_wr;
  logic [15:0] prev_rd;
  logic        wait_on, held_prev;
  logic [63:0] held_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] word_of(input int k, input logic [7:0] seed);
    logic [7:0] b;
    b = (k < DIM) ? seed + 8'(k) : seed + 8'h0F + 8'(k - DIM);
    return {8{b}};
  endfunction

  // Expected transactions for one complete job.
  task automatic push_job(input logic [7:0] seed);
    wr_t e;
    logic [15:0] a;
    for (int k = 0; k < NW; k++) begin
      e.a = (k < DIM) ? 16'h0100 + 16'(8 * k) : 16'h0200 + 16'(8 * (k - DIM));
      e.d = word_of(k, seed);
      expw.push_back(e);
    end
    e.a = 16'h0400;
    e.d = 64'h0;
    expw.push_back(e);
    for (int w = 0; w < NW; w++) begin
      a = 16'h0300 + 16'(16 * (w / 2) + 8 * (w % 2));
      expr.push_back(a);
      expo.push_back({48'hC000_0000_0000, a});
    end
  endtask

  task automatic clear_logs();
    n_writes = 0; n_mm = 0; n_done = 0; n_stall = 0; mm_idle = -1;
    first_wr = 16'hFFFF;
    out_log.delete();
  endtask

  // Compare process: checks DUT outputs against the model every cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_rd = 16'h0; held_prev = 1'b0; wait_on = 1'b0; idle_cnt = 0;
    end else begin
      if (tpu_r_w || (tpu_addr != 16'h0) || out_valid) chk("busy_in_job", 64'(busy), 64'd1);
      if (in_ready) chk("busy_with_ready", 64'(busy), 64'd1);
      if (done) begin
        chk("busy_at_done", 64'(busy), 64'd0);
        n_done++;
      end
      if (in_ready && !in_valid) begin
        chk("bubble_rw", 64'(tpu_r_w), 64'd0);
        chk("bubble_addr", 64'(tpu_addr), 64'd0);
      end
      if (tpu_r_w) begin
        if (expw.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_write actual addr=%h required none", tpu_addr);
        end else begin
          wr_t e;
          e = expw.pop_front();
          chk("wr_addr", 64'(tpu_addr), 64'(e.a));
          chk("wr_data", tpu_wdata, e.d);
        end
        if (n_writes == 0) first_wr = tpu_addr;
        n_writes++;
        if (tpu_addr == 16'h0400) begin
          n_mm++; wait_on = 1'b1; idle_cnt = 0;
        end
        prev_rd = 16'h0;
      end else if (tpu_addr != 16'h0) begin
        if (tpu_addr != prev_rd) begin
          if (expr.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_read actual addr=%h required none", tpu_addr);
          end else begin
            chk("rd_addr", 64'(tpu_addr), 64'(expr.pop_front()));
          end
          if (wait_on) begin
            mm_idle = idle_cnt;
            chk("mm_wait_len", 64'(idle_cnt), 64'(MM_CYCLES));
            wait_on = 1'b0;
          end
        end
        prev_rd = tpu_addr;
      end else begin
        prev_rd = 16'h0;
        if (wait_on) idle_cnt++;
      end
      if (out_valid) begin
        chk("no_rd_while_out", 64'(tpu_addr), 64'd0);
        if (held_prev) chk("out_stable", out_data, held_data);
        if (!out_ready) n_stall++;
        else if (expo.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_out actual=%h required none", out_data);
        end else begin
          chk("out_data", out_data, expo.pop_front());
          out_log.push_back(out_data);
        end
      end
      held_prev = out_valid && !out_ready;
      held_data = out_data;
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_data"}, out_data, 64'd0);
    chk({tag, "_rw"}, 64'(tpu_r_w), 64'd0);
    chk({tag, "_addr"}, 64'(tpu_addr), 64'd0);
    chk({tag, "_wdata"}, tpu_wdata, 64'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Feed up to nwords input words; bub selects the 1,0,0,1 valid pattern.
  task automatic load_words(input int bub, input int nwords, input logic [7:0] seed);
    int k = 0;
    int p = 0;
    logic hs;
    while (k < nwords && p < 200) begin
      in_valid = (bub == 0) || (p % 4 == 0) || (p % 4 == 3);
      in_data  = word_of(k, seed);
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) k++;
      p++;
    end
    in_valid = 1'b0;
    chk("load_count", 64'(k), 64'(nwords));
  endtask

  task automatic run_job(input int bub, input int stall, input int sw, input logic [7:0] seed);
    int stall_left;
    logic got;
    clear_logs();
    push_job(seed);
    pulse_start();
    load_words(bub, NW, seed);
    got = 1'b0;
    stall_left = (stall != 0) ? 5 : 0;
    out_ready = 1'b1;
    for (int c = 0; c < 600 && !got; c++) begin
      start = (sw != 0) && (c == 5);
      @(negedge clk);
      if (done) got = 1'b1;
      @(posedge clk); #1;
      if (stall_left > 0 && out_valid && out_log.size() == 3) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
    chk("done_seen", 64'(got), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("done_pulses", 64'(n_done), 64'd1);
    chk("mm_once", 64'(n_mm), 64'd1);
    chk("write_count", 64'(n_writes), 64'(NW + 1));
    chk("out_count", 64'(out_log.size()), 64'(NW));
    chk("wq_empty", 64'(expw.size()), 64'd0);
    chk("rq_empty", 64'(expr.size()), 64'd0);
    chk("busy_after", 64'(busy), 64'd0);
    if (stall != 0) chk("stall_cycles", 64'(n_stall), 64'd5);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    clear_logs();
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("idle");
    @(posedge clk); #1;

    // Input offered while idle must not be accepted.
    in_valid = 1'b1;
    in_data  = 64'hDEAD_BEEF_0000_0001;
    repeat (3) begin
      @(negedge clk);
      chk("idle_in_ready", 64'(in_ready), 64'd0);
      chk("idle_no_write", 64'(tpu_r_w), 64'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;

    // Nominal job plus literal pins of the first/last transactions.
    run_job(0, 0, 0, 8'h01);
    chk("pin_first_wr", 64'(first_wr), 64'h0100);
    chk("pin_writes", 64'(n_writes), 64'd17);
    chk("pin_mm_idle", 64'(mm_idle), 64'd24);
    chk("pin_out0", out_log[0], 64'hC000_0000_0000_0300);
    chk("pin_out3", out_log[3], 64'hC000_0000_0000_0318);
    chk("pin_out15", out_log[15], 64'hC000_0000_0000_0378);

    run_job(1, 0, 0, 8'h21);   // input bubbles
    run_job(0, 1, 0, 8'h41);   // output backpressure on word 3
    run_job(0, 0, 1, 8'h61);   // start pulsed during MM_WAIT
    repeat (5) @(posedge clk);
    #1;
    chk("no_restart_busy", 64'(busy), 64'd0);

    // Reset in the middle of loading A.
    clear_logs();
    push_job(8'h81);
    pulse_start();
    load_words(0, 5, 8'h81);
    in_valid = 1'b1;
    in_data  = word_of(5, 8'h81);
    #2;
    chk("pre_reset_write", 64'(tpu_r_w), 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    in_valid = 1'b0;
    expw.delete(); expr.delete(); expo.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_job(0, 0, 0, 8'hA1);
    chk("pin_restart_wr", 64'(first_wr), 64'h0100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
